// File: rtl/i2c_target.sv
// I2C target exposing a byte-addressed register map: pointer write, burst write
// with one-cycle strobes, and burst read from a combinational register source.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_strobe,
    output logic       busy
);
    // state     | meaning
    // IDLE      | not addressed; wait for START
    // ADDR      | shifting in 7-bit address + R/W
    // ADDR_ACK  | driving ACK for our address
    // PTR       | shifting in register pointer
    // PTR_ACK   | driving ACK for pointer byte
    // WDATA     | shifting in a write data byte
    // WDATA_ACK | driving ACK for a write data byte
    // RDATA     | shifting a read byte out
    // RACK      | controller ACK/NACK for the read byte
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_h;
    logic       sda_s1, sda_s2, sda_h;
    logic [3:0] cnt;
    logic [7:0] sr;
    logic [7:0] tx;
    logic [7:0] ptr;
    logic       rw;

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_s2 & ~scl_h;
    assign scl_fall = ~scl_s2 & scl_h;
    assign start_ev = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_ev  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign reg_addr = ptr;

    // Synchronizers reset to the idle-bus level so release does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {scl_s1, scl_s2, scl_h} <= 3'b111;
            {sda_s1, sda_s2, sda_h} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_h} <= {sda_in, sda_s1, sda_s2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            tx        <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_strobe <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_ev) begin
                state  <= ADDR;
                cnt    <= '0;
                busy   <= 1'b1;
                sda_oe <= 1'b0;
            end else if (stop_ev) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            sr  <= {sr[6:0], sda_s2};
                            cnt <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            if (state == ADDR) begin
                                if (sr[7:1] == DEV_ADDR) begin
                                    rw     <= sr[0];
                                    sda_oe <= 1'b1;
                                    state  <= ADDR_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (state == PTR) begin
                                ptr    <= sr;
                                sda_oe <= 1'b1;
                                state  <= PTR_ACK;
                            end else begin
                                wr_addr   <= ptr;
                                wr_data   <= sr;
                                wr_strobe <= 1'b1;
                                ptr       <= ptr + 8'd1;
                                sda_oe    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (state == ADDR_ACK && rw) begin
                                tx     <= {reg_data[6:0], 1'b0};
                                sda_oe <= ~reg_data[7];
                                cnt    <= 4'd1;
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                cnt    <= '0;
                                state  <= (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RACK;
                            end else begin
                                sda_oe <= ~tx[7];
                                tx     <= {tx[6:0], 1'b0};
                                cnt    <= cnt + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        // Every byte sent advances the pointer, NACKed or not.
                        if (scl_rise) begin
                            ptr <= ptr + 8'd1;
                            if (sda_s2) state <= IDLE;
                        end else if (scl_fall) begin
                            tx     <= {reg_data[6:0], 1'b0};
                            sda_oe <= ~reg_data[7];
                            cnt    <= 4'd1;
                            state  <= RDATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, write-strobe scoreboard, directed checks.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_in, sda_oe, wr_strobe, busy;
    logic [7:0] reg_addr, reg_data, wr_addr, wr_data;

    int checks = 0;
    int errors = 0;
    int oe_cycles = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic        prev_strobe = 1'b0;

    always #5 clk = ~clk;
    assign sda_in   = sda_drv & ~sda_oe;
    assign reg_data = reg_addr ^ 8'h5A;

    i2c_target #(.DEV_ADDR(7'h42)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_data(reg_data), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .busy(busy)
    );

    // Write-strobe monitor: pops expected {addr,data} whenever the DUT strobes.
    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
        if (wr_strobe) begin
            checks++;
            if (prev_strobe) begin
                errors++;
                $display("FAIL wr_strobe_width got 2+ cycles expected 1");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_strobe_unexpected got %h/%h expected none", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL wr_strobe_data got %h/%h expected %h/%h",
                             wr_addr, wr_data, mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
        prev_strobe <= wr_strobe;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; #Q;
        scl = 1'b1;     #Q;
        sda_drv = 1'b0; #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #Q;
        scl = 1'b1;     #Q;
        sda_drv = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; #Q;
        scl = 1'b1;  #(2*Q);
        scl = 1'b0;  #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; #Q;
        scl = 1'b1;     #Q;
        b = sda_in;     #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    logic       ack;
    logic [7:0] rd;
    int         oe_before;

    initial begin
        #47 rst_n = 1'b1;
        #20;
        chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        chk("rst_reg_addr", {8'd0, reg_addr}, 16'd0);
        chk("rst_wr_addr", {8'd0, wr_addr}, 16'd0);
        chk("rst_wr_data", {8'd0, wr_data}, 16'd0);
        chk("rst_wr_strobe", {15'd0, wr_strobe}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);

        // Write burst
        exp_q.push_back(16'h10A5);
        exp_q.push_back(16'h113C);
        i2c_start();
        chk("wr_busy", {15'd0, busy}, 16'd1);
        wbyte(8'h84, ack); chk("wr_ack_addr", {15'd0, ack}, 16'd0);
        wbyte(8'h10, ack); chk("wr_ack_ptr", {15'd0, ack}, 16'd0);
        wbyte(8'hA5, ack); chk("wr_ack_d0", {15'd0, ack}, 16'd0);
        wbyte(8'h3C, ack); chk("wr_ack_d1", {15'd0, ack}, 16'd0);
        i2c_stop();
        #Q;
        chk("wr_reg_addr", {8'd0, reg_addr}, 16'h0012);
        chk("wr_busy_end", {15'd0, busy}, 16'd0);

        // Read burst with repeated START
        i2c_start();
        wbyte(8'h84, ack); chk("rd_ack_waddr", {15'd0, ack}, 16'd0);
        wbyte(8'h04, ack); chk("rd_ack_ptr", {15'd0, ack}, 16'd0);
        i2c_start();
        wbyte(8'h85, ack); chk("rd_ack_raddr", {15'd0, ack}, 16'd0);
        rbyte(rd, 1'b0); chk("rd_byte0", {8'd0, rd}, 16'h005E);
        rbyte(rd, 1'b0); chk("rd_byte1", {8'd0, rd}, 16'h005F);
        rbyte(rd, 1'b1); chk("rd_byte2", {8'd0, rd}, 16'h005C);
        chk("rd_sda_released", {15'd0, sda_oe}, 16'd0);
        i2c_stop();
        #Q;
        chk("rd_reg_addr", {8'd0, reg_addr}, 16'h0007);

        // Address mismatch
        oe_before = oe_cycles;
        i2c_start();
        wbyte(8'h86, ack); chk("mm_nack_addr", {15'd0, ack}, 16'd1);
        wbyte(8'h10, ack); chk("mm_nack_data", {15'd0, ack}, 16'd1);
        i2c_stop();
        #Q;
        chk("mm_no_oe", oe_cycles - oe_before, 16'd0);
        chk("mm_reg_addr", {8'd0, reg_addr}, 16'h0007);

        // Pointer wrap on read
        i2c_start();
        wbyte(8'h84, ack);
        wbyte(8'hFF, ack); chk("wrap_ack_ptr", {15'd0, ack}, 16'd0);
        i2c_start();
        wbyte(8'h85, ack); chk("wrap_ack_raddr", {15'd0, ack}, 16'd0);
        rbyte(rd, 1'b0); chk("wrap_byte_ff", {8'd0, rd}, 16'h00A5);
        rbyte(rd, 1'b1); chk("wrap_byte_00", {8'd0, rd}, 16'h005A);
        i2c_stop();
        #Q;
        chk("wrap_reg_addr", {8'd0, reg_addr}, 16'h0001);

        // STOP after 4 data bits
        i2c_start();
        wbyte(8'h84, ack);
        wbyte(8'h20, ack); chk("sm_ack_ptr", {15'd0, ack}, 16'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        #Q;
        chk("sm_reg_addr", {8'd0, reg_addr}, 16'h0020);
        chk("sm_busy", {15'd0, busy}, 16'd0);
        chk("sm_sda_oe", {15'd0, sda_oe}, 16'd0);

        // Reset while driving ACK of a read address
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(logic'((8'h85 >> i) & 8'h01));
        sda_drv = 1'b1; #Q;
        chk("rst_mid_oe_before", {15'd0, sda_oe}, 16'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe_async", {15'd0, sda_oe}, 16'd0);
        chk("rst_mid_reg_addr", {8'd0, reg_addr}, 16'd0);
        chk("rst_mid_busy", {15'd0, busy}, 16'd0);
        chk("rst_mid_wr", {wr_addr, wr_data}, 16'd0);
        #30 rst_n = 1'b1;
        #30;
        exp_q.push_back(16'h3077);
        i2c_start();
        wbyte(8'h84, ack); chk("post_rst_ack_addr", {15'd0, ack}, 16'd0);
        wbyte(8'h30, ack); chk("post_rst_ack_ptr", {15'd0, ack}, 16'd0);
        wbyte(8'h77, ack); chk("post_rst_ack_data", {15'd0, ack}, 16'd0);
        i2c_stop();
        #Q;
        chk("post_rst_reg_addr", {8'd0, reg_addr}, 16'h0031);

        chk("strobes_outstanding", exp_q.size(), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
